// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - ProtoCore multi-cycle sequencer: fetch, decode, execute, memory, halt.
module core_sequencer #(
    parameter int PC_WIDTH  = 8,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [23:0]          imem_rdata,
    output logic [23:0]          instruction,
    input  logic                 dec_write_en,
    input  logic                 dec_is_load,
    input  logic                 dec_ram_write_en,
    input  logic                 dec_halt,
    input  logic                 dec_pc_overwrite,
    input  logic [7:0]           jump_target,
    output logic                 ram_req,
    input  logic                 ram_ack,
    output logic                 rf_write_strobe,
    output logic                 ram_write_strobe,
    input  logic                 resume,
    output logic                 halted,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                r_state;
    state_t                w_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [23:0]           r_instr;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic [PC_WIDTH-1:0]   w_target;
    logic                  w_pc_inc;
    logic                  w_pc_jump;
    logic                  w_retire;
    logic                  w_load_ir;
    logic                  w_rf_strobe;
    logic                  w_ram_strobe;

    generate
        if (PC_WIDTH > 8) begin : g_tgt_ext
            assign w_target = {{(PC_WIDTH-8){1'b0}}, jump_target};
        end else begin : g_tgt_trunc
            assign w_target = jump_target[PC_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        w_next       = r_state;
        w_pc_inc     = 1'b0;
        w_pc_jump    = 1'b0;
        w_retire     = 1'b0;
        w_load_ir    = 1'b0;
        w_rf_strobe  = 1'b0;
        w_ram_strobe = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_load_ir = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (dec_halt) begin
                    w_retire = 1'b1;
                    w_next   = S_HALTED;
                end else if (dec_is_load || dec_ram_write_en) begin
                    w_next = S_MEM;
                end else begin
                    w_rf_strobe = dec_write_en;
                    w_pc_jump   = dec_pc_overwrite;
                    w_pc_inc    = !dec_pc_overwrite;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_MEM: begin
                // Loads and stores always fall through to pc+1, even if a branch flag is set.
                if (ram_ack) begin
                    w_rf_strobe  = dec_is_load;
                    w_ram_strobe = !dec_is_load;
                    w_pc_inc     = 1'b1;
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    w_pc_inc = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= PC_WIDTH'(RESET_PC);
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_ir) begin
                r_instr <= imem_rdata;
            end
            if (w_pc_jump) begin
                r_pc <= w_target;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + PC_ONE;
            end
            if (w_retire && (r_retired != {CNT_WIDTH{1'b1}})) begin
                r_retired <= r_retired + CNT_ONE;
            end
        end
    end

    // Gating with rst keeps the fetch request low while reset is held, even though state is FETCH.
    assign imem_req         = rst && (r_state == S_FETCH);
    assign imem_addr        = r_pc;
    assign instruction      = r_instr;
    assign ram_req          = (r_state == S_MEM);
    assign rf_write_strobe  = w_rf_strobe;
    assign ram_write_strobe = w_ram_strobe;
    assign halted           = (r_state == S_HALTED);
    assign pc               = r_pc;
    assign retired          = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench for core_sequencer acting as memory and decoder.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [23:0] imem_rdata = '0;
    logic [23:0] instruction;
    logic        dec_write_en = 1'b0;
    logic        dec_is_load = 1'b0;
    logic        dec_ram_write_en = 1'b0;
    logic        dec_halt = 1'b0;
    logic        dec_pc_overwrite = 1'b0;
    logic [7:0]  jump_target = '0;
    logic        ram_req;
    logic        ram_ack = 1'b0;
    logic        rf_write_strobe;
    logic        ram_write_strobe;
    logic        resume = 1'b0;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] retired;

    core_sequencer #(.PC_WIDTH(8), .RESET_PC(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction),
        .dec_write_en(dec_write_en), .dec_is_load(dec_is_load), .dec_ram_write_en(dec_ram_write_en),
        .dec_halt(dec_halt), .dec_pc_overwrite(dec_pc_overwrite), .jump_target(jump_target),
        .ram_req(ram_req), .ram_ack(ram_ack),
        .rf_write_strobe(rf_write_strobe), .ram_write_strobe(ram_write_strobe),
        .resume(resume), .halted(halted), .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ret;
        int          cyc;
        int          rf;
        int          ram;
        int          req;
    } exp_t;

    exp_t        sbq[$];
    int          passed = 0;
    int          total = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    int          obs_cyc, obs_rf, obs_ram, obs_req, obs_both;

    function automatic void predict(input logic wr, ld, st, hl, br, input logic [7:0] tgt, input int wt);
        exp_t e;
        if (hl) begin
            e.cyc = 3; e.rf = 0; e.ram = 0; e.req = 0;
        end else if (ld || st) begin
            e.cyc = 4 + wt; e.rf = ld ? 1 : 0; e.ram = ld ? 0 : 1; e.req = 1 + wt;
            m_pc = m_pc + 8'd1;
        end else begin
            e.cyc = 3; e.rf = wr ? 1 : 0; e.ram = 0; e.req = 0;
            m_pc = br ? tgt : m_pc + 8'd1;
        end
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        e.pc = m_pc;
        e.ret = m_ret;
        sbq.push_back(e);
    endfunction

    function automatic logic [47:0] obs_vec();
        return {pc, retired, 8'(obs_cyc), 4'(obs_rf), 4'(obs_ram), 4'(obs_req), 4'(obs_both)};
    endfunction

    function automatic logic [47:0] exp_vec(input exp_t e);
        return {e.pc, e.ret, 8'(e.cyc), 4'(e.rf), 4'(e.ram), 4'(e.req), 4'd0};
    endfunction

    // Called just after a negedge with the DUT in FETCH; returns just after the negedge it is back in FETCH or HALTED.
    task automatic run(input logic [23:0] word, input logic wr, ld, st, hl, br,
                       input logic [7:0] tgt, input int wt);
        predict(wr, ld, st, hl, br, tgt, wt);
        imem_rdata = word; dec_write_en = wr; dec_is_load = ld; dec_ram_write_en = st;
        dec_halt = hl; dec_pc_overwrite = br; jump_target = tgt; imem_ack = 1'b1;
        obs_cyc = 0; obs_rf = 0; obs_ram = 0; obs_req = 0; obs_both = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            obs_cyc++;
            if (ram_req) begin
                obs_req++;
                ram_ack = (obs_req > wt);
            end else begin
                ram_ack = 1'b0;
            end
            #1;
            if (rf_write_strobe) obs_rf++;
            if (ram_write_strobe) obs_ram++;
            if (rf_write_strobe && ram_write_strobe) obs_both++;
            if (imem_req || halted) begin
                imem_ack = 1'b0;
                ram_ack = 1'b0;
                return;
            end
        end
        total++;
        $display("FAIL run_timeout: instruction %h still running after 40 cycles", word);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({imem_req, ram_req, rf_write_strobe, ram_write_strobe, halted, pc, instruction, retired} !== '0)
            $display("FAIL reset_outputs: got req=%b ram_req=%b halted=%b pc=%h ir=%h ret=%h, want all zero",
                     imem_req, ram_req, halted, pc, instruction, retired);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00})
            $display("FAIL reset_first_fetch: got req=%b addr=%h, want req=1 addr=00", imem_req, imem_addr);
        else passed++;
        m_pc = 8'h00;
        m_ret = 16'h0000;
    endtask

    task automatic test_alu();
        exp_t e;
        run(24'h012300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL alu_op: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
        total++;
        if ({instruction, imem_addr} !== {24'h012300, m_pc})
            $display("FAIL alu_ir_addr: got ir=%h addr=%h want ir=012300 addr=%h", instruction, imem_addr, m_pc);
        else passed++;
    endtask

    task automatic test_jump();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run(24'h100000 + 24'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 0);
            e = sbq.pop_front();
            total++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL nop_%0d: got %h want %h", i, obs_vec(), exp_vec(e));
            else passed++;
        end
        run(24'hE0002A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 0);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL jump: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
    endtask

    task automatic test_mem();
        exp_t e;
        run(24'h400000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 2);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL load_wait2: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
        run(24'h500000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 0);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL store_nowait: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
    endtask

    task automatic test_halt();
        exp_t e;
        int   idle_strobes;
        run(24'hE00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 0);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL jump_to_halt: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
        run(24'hF00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        e = sbq.pop_front();
        total++;
        if ({obs_vec(), halted} !== {exp_vec(e), 1'b1})
            $display("FAIL halt: got %h halted=%b want %h halted=1", obs_vec(), halted, exp_vec(e));
        else passed++;
        idle_strobes = 0;
        imem_ack = 1'b1;
        ram_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (rf_write_strobe || ram_write_strobe || imem_req || ram_req) idle_strobes++;
        end
        imem_ack = 1'b0;
        ram_ack = 1'b0;
        total++;
        if ({halted, pc, 8'(idle_strobes)} !== {1'b1, 8'h10, 8'd0})
            $display("FAIL halted_idle: got halted=%b pc=%h activity=%0d want halted=1 pc=10 activity=0",
                     halted, pc, idle_strobes);
        else passed++;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #1;
        m_pc = m_pc + 8'd1;
        total++;
        if ({halted, imem_req, pc, retired} !== {1'b0, 1'b1, m_pc, m_ret})
            $display("FAIL resume: got halted=%b req=%b pc=%h ret=%h want halted=0 req=1 pc=%h ret=%h",
                     halted, imem_req, pc, retired, m_pc, m_ret);
        else passed++;
        resume = 1'b1;
        run(24'h020000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        resume = 1'b0;
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL resume_running: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
    endtask

    task automatic test_wrap_saturate();
        exp_t e;
        run(24'hE000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 0);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL jump_ff: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
        run(24'h030000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) $display("FAIL pc_wrap: got %h want %h", obs_vec(), exp_vec(e));
        else passed++;
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            run(24'h040000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
            e = sbq.pop_front();
            total++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL saturate_%0d: got %h want %h", i, obs_vec(), exp_vec(e));
            else passed++;
        end
    endtask

    task automatic test_reset_mem();
        bit seen = 1'b0;
        imem_rdata = 24'h410000; dec_is_load = 1'b1; dec_write_en = 1'b1;
        dec_ram_write_en = 1'b0; dec_halt = 1'b0; dec_pc_overwrite = 1'b0; imem_ack = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            #1;
            seen = ram_req;
        end
        total++;
        if (!seen) $display("FAIL reset_mem_reach: got ram_req=0 want ram_req=1 within 10 cycles");
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({ram_req, imem_req, pc} !== {1'b0, 1'b0, 8'h00})
            $display("FAIL reset_mem_drop: got ram_req=%b req=%b pc=%h want 0 0 00", ram_req, imem_req, pc);
        else passed++;
        @(negedge clk);
        ram_ack = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({rf_write_strobe, ram_write_strobe, ram_req} !== 3'b000)
            $display("FAIL reset_mem_late_ack: got rf=%b ram=%b ram_req=%b want 000",
                     rf_write_strobe, ram_write_strobe, ram_req);
        else passed++;
        @(negedge clk);
        ram_ack = 1'b0;
        #1;
        total++;
        if ({imem_req, retired, instruction} !== {1'b1, 16'h0000, 24'h000000})
            $display("FAIL reset_mem_after: got req=%b ret=%h ir=%h want 1 0000 000000", imem_req, retired, instruction);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_jump();
        test_mem();
        test_halt();
        test_wrap_saturate();
        test_reset_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
